// File: rtl/game_state_ctrl_if.sv
// Signal bundle between the game sequencer and its surroundings: keycode and
// frame inputs, player death flags, and the state/winner/blink outputs that
// feed color_mapper and the player modules.
interface game_state_ctrl_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       p1_dead;
    logic       p2_dead;
    logic [1:0] game_state;
    logic       round_start;
    logic [1:0] winner;
    logic       start_blink;

    // System side: drives frame/key/death inputs, observes sequencer outputs
    modport master (
        output frame_clk, keycode, p1_dead, p2_dead,
        input  game_state, round_start, winner, start_blink
    );

    // Sequencer side
    modport slave (
        input  frame_clk, keycode, p1_dead, p2_dead,
        output game_state, round_start, winner, start_blink
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: START menu -> PLAY -> OVER panel -> START.
// Produces the game_state code for color_mapper, a one-cycle round_start
// pulse for the players, the winner code and the start-menu blink gate.
module game_state_ctrl #(
    parameter logic [7:0]  KEY_START    = 8'h28,
    parameter int unsigned OVER_FRAMES  = 120,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    game_state_ctrl_if.slave  gs_if
);

    typedef enum logic [1:0] {
        ST_START   = 2'b00,
        ST_PLAY    = 2'b01,
        ST_OVER    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] OVER_MAX  = CNT_W'(OVER_FRAMES);
    localparam logic [CNT_W-1:0] BLINK_MAX = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    logic             key_match_s;
    logic             frame_q_r;
    logic             frame_tick_r;
    logic             key_q_r;
    logic             key_press_r;
    state_t           state_r;
    logic             round_start_r;
    logic [1:0]       winner_r;
    logic             blink_r;
    logic [CNT_W-1:0] cnt_r;

    // Reset synchronizer: assertion takes effect at once, release is aligned to Clk
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s     = rst_sync_r[1];
    assign key_match_s = (gs_if.keycode == KEY_START);

    // Rising-edge detection of the frame strobe and of the start key (a held key gives one press)
    always_ff @(posedge Clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            frame_q_r    <= 1'b0;
            frame_tick_r <= 1'b0;
            key_q_r      <= 1'b0;
            key_press_r  <= 1'b0;
        end else begin
            frame_q_r    <= gs_if.frame_clk;
            frame_tick_r <= gs_if.frame_clk & ~frame_q_r;
            key_q_r      <= key_match_s;
            key_press_r  <= key_match_s & ~key_q_r;
        end
    end

    // Game FSM with registered outputs and the shared blink / over-hold frame counter
    always_ff @(posedge Clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r       <= ST_START;
            round_start_r <= 1'b0;
            winner_r      <= 2'b00;
            blink_r       <= 1'b1;
            cnt_r         <= CNT_ZERO;
        end else begin
            round_start_r <= 1'b0;
            case (state_r)
                ST_START: begin
                    if (key_press_r) begin
                        // A key press beats a same-cycle frame tick: counter restarts
                        state_r       <= ST_PLAY;
                        round_start_r <= 1'b1;
                        winner_r      <= 2'b00;
                        cnt_r         <= CNT_ZERO;
                        blink_r       <= 1'b1;
                    end else if (frame_tick_r) begin
                        if (cnt_r == BLINK_MAX) begin
                            cnt_r   <= CNT_ZERO;
                            blink_r <= ~blink_r;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_PLAY: begin
                    cnt_r   <= CNT_ZERO;
                    blink_r <= 1'b1;
                    if (frame_tick_r && (gs_if.p1_dead || gs_if.p2_dead)) begin
                        // P1 dead means P2 wins (10), P2 dead means P1 wins (01), both is a draw (11)
                        state_r  <= ST_OVER;
                        winner_r <= {gs_if.p1_dead, gs_if.p2_dead};
                    end else begin
                        state_r <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    blink_r <= 1'b1;
                    if (key_press_r && (cnt_r == OVER_MAX)) begin
                        state_r  <= ST_START;
                        winner_r <= 2'b00;
                        cnt_r    <= CNT_ZERO;
                    end else if (frame_tick_r && (cnt_r < OVER_MAX)) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r  <= ST_START;
                    winner_r <= 2'b00;
                    cnt_r    <= CNT_ZERO;
                    blink_r  <= 1'b1;
                end
            endcase
        end
    end

    assign gs_if.game_state  = state_r;
    assign gs_if.round_start = round_start_r;
    assign gs_if.winner      = winner_r;
    assign gs_if.start_blink = blink_r;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl. Expected output words
// {game_state, round_start, winner, start_blink} are queued as stimulus is
// applied and popped for comparison once the sequencer has had time to react.
module tb_game_state_ctrl;

    logic Clk;
    logic Reset_n;

    game_state_ctrl_if bus ();

    game_state_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .gs_if   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int         errors = 0;
    int         checks = 0;
    string      tag_q[$];
    logic [5:0] exp_q[$];

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One frame: strobe high two cycles, low two cycles
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_clk = 1'b1;
            step(2);
            bus.frame_clk = 1'b0;
            step(2);
        end
    endtask

    task automatic press();
        bus.keycode = 8'h28;
        step(3);
        bus.keycode = 8'h00;
        step(2);
    endtask

    task automatic expect_out(input string tag, input logic [1:0] gs, input logic rs,
                              input logic [1:0] win, input logic blink);
        tag_q.push_back(tag);
        exp_q.push_back({gs, rs, win, blink});
    endtask

    task automatic check_out();
        logic [5:0] obs;
        logic [5:0] e;
        string      t;
        obs = {bus.game_state, bus.round_start, bus.winner, bus.start_blink};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%b expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed {gs,rs,win,blink}=%b expected=%b", t, obs, e);
            end
        end
    endtask

    initial begin
        Reset_n       = 1'b0;
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'h00;
        bus.p1_dead   = 1'b0;
        bus.p2_dead   = 1'b0;

        // Reset values
        expect_out("reset", 2'b00, 1'b0, 2'b00, 1'b1);
        step(3);
        check_out();
        Reset_n = 1'b1;
        step(4);

        // 1: held Enter enters PLAY once with a single round_start pulse
        bus.keycode = 8'h28;
        expect_out("t1_key_registered", 2'b00, 1'b0, 2'b00, 1'b1);
        expect_out("t1_play_pulse",     2'b01, 1'b1, 2'b00, 1'b1);
        expect_out("t1_pulse_done",     2'b01, 1'b0, 2'b00, 1'b1);
        expect_out("t1_held_key",       2'b01, 1'b0, 2'b00, 1'b1);
        step(1); check_out();
        step(1); check_out();
        step(1); check_out();
        step(7); check_out();
        bus.keycode = 8'h00;

        // Key press in PLAY is ignored
        expect_out("play_key_ignored", 2'b01, 1'b0, 2'b00, 1'b1);
        press();
        check_out();

        // 2: p2 death between frames waits for the frame edge, then P1 wins
        bus.p2_dead = 1'b1;
        expect_out("t2_wait_frame", 2'b01, 1'b0, 2'b00, 1'b1);
        step(3); check_out();
        bus.frame_clk = 1'b1;
        expect_out("t2_tick_registered", 2'b01, 1'b0, 2'b00, 1'b1);
        expect_out("t2_over_p1_wins",    2'b10, 1'b0, 2'b01, 1'b1);
        step(1); check_out();
        step(1); check_out();
        bus.frame_clk = 1'b0;
        step(2);

        // 4: OVER holds until 120 frames; early presses are dropped
        frames(50);
        expect_out("t4_press_at_50", 2'b10, 1'b0, 2'b01, 1'b1);
        press(); check_out();
        frames(69);
        expect_out("t4_press_at_119", 2'b10, 1'b0, 2'b01, 1'b1);
        press(); check_out();
        frames(1);
        expect_out("t4_press_at_120", 2'b00, 1'b0, 2'b00, 1'b1);
        press(); check_out();

        // 5: START blink toggles every 30 frames; deaths in START ignored
        frames(29);
        expect_out("t5_frame29", 2'b00, 1'b0, 2'b00, 1'b1);
        check_out();
        bus.p2_dead = 1'b0;
        frames(1);
        expect_out("t5_frame30", 2'b00, 1'b0, 2'b00, 1'b0);
        check_out();
        frames(29);
        expect_out("t5_frame59", 2'b00, 1'b0, 2'b00, 1'b0);
        check_out();
        frames(1);
        expect_out("t5_frame60", 2'b00, 1'b0, 2'b00, 1'b1);
        check_out();
        frames(5);
        expect_out("t5_frame65", 2'b00, 1'b0, 2'b00, 1'b1);
        check_out();
        expect_out("t5_play_blink", 2'b01, 1'b0, 2'b00, 1'b1);
        press(); check_out();

        // 3: simultaneous deaths give a draw
        bus.p1_dead = 1'b1;
        bus.p2_dead = 1'b1;
        expect_out("t3_draw", 2'b10, 1'b0, 2'b11, 1'b1);
        frames(1); check_out();
        bus.p1_dead = 1'b0;
        bus.p2_dead = 1'b0;
        frames(120);
        expect_out("t3_winner_held", 2'b10, 1'b0, 2'b11, 1'b1);
        check_out();
        expect_out("t3_back_to_start", 2'b00, 1'b0, 2'b00, 1'b1);
        press(); check_out();
        expect_out("t3_replay", 2'b01, 1'b0, 2'b00, 1'b1);
        press(); check_out();

        // 6: asynchronous reset mid-PLAY, no round_start on release
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        expect_out("t6_async_reset", 2'b00, 1'b0, 2'b00, 1'b1);
        check_out();
        step(2);
        Reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_out("t6_release", 2'b00, 1'b0, 2'b00, 1'b1);
            step(1);
            check_out();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
